// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl: one-MAC sequencer for y = act(W*x + b); DENSE_SEQ_SAT_EN selects saturation instead of wrap
module dense_seq_ctrl #(
  parameter int B = 15,
  parameter int M = 64,
  parameter int N = 2,
  parameter int WIDTH = 16,
  parameter int FRAC = 8,
  parameter int ACC_W = 2 * WIDTH + $clog2(N) + 2,
  localparam int WAW = (M * N > 1) ? $clog2(M * N) : 1,
  localparam int XAW = (B * N > 1) ? $clog2(B * N) : 1,
  localparam int MW = (M > 1) ? $clog2(M) : 1,
  localparam int BW = (B > 1) ? $clog2(B) : 1,
  localparam int KW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    relu_en,
  output logic                    busy,
  output logic                    done,
  output logic                    w_rd_en,
  output logic [WAW-1:0]          w_addr,
  input  logic signed [WIDTH-1:0] w_data,
  output logic                    x_rd_en,
  output logic [XAW-1:0]          x_addr,
  input  logic signed [WIDTH-1:0] x_data,
  output logic                    b_rd_en,
  output logic [MW-1:0]           b_addr,
  input  logic signed [WIDTH-1:0] b_data,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic signed [WIDTH-1:0] y_data,
  output logic [BW-1:0]           y_batch,
  output logic [MW-1:0]           y_neuron
);
  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_OUT, S_DONE} state_t;
  state_t r_state, w_next;
  logic [BW-1:0] r_b;
  logic [MW-1:0] r_m;
  logic [KW-1:0] r_k, w_n;
  logic signed [ACC_W-1:0] r_acc, w_base, w_sum, w_sh;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [WIDTH-1:0] r_y, w_post, w_y;
  logic r_relu, w_last_k, w_last_m, w_last_item, w_fire, w_rd;
  assign w_last_k = r_k == KW'(N - 1);
  assign w_last_m = r_m == MW'(M - 1);
  assign w_last_item = w_last_m && r_b == BW'(B - 1);
  assign w_fire = r_state == S_OUT && y_ready;
  assign w_prod = w_data * x_data;
  assign w_base = (r_k == '0) ? ({{(ACC_W-WIDTH){b_data[WIDTH-1]}}, b_data} <<< FRAC) : r_acc;
  assign w_sum = w_base + {{(ACC_W-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
  assign w_sh = w_sum >>> FRAC;
`ifdef DENSE_SEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  assign w_post = (w_sh > MAXV) ? MAXV[WIDTH-1:0] : (w_sh < MINV) ? MINV[WIDTH-1:0] : w_sh[WIDTH-1:0];
`else
  assign w_post = w_sh[WIDTH-1:0];
`endif
  assign w_y = (r_relu && w_post[WIDTH-1]) ? '0 : w_post;
  // BIAS fetches n=0; each MAC cycle but the last prefetches the next term
  assign w_rd = r_state == S_BIAS || (r_state == S_MAC && !w_last_k);
  assign w_n = (r_state == S_BIAS) ? '0 : KW'(r_k + 1'b1);
  assign w_rd_en = w_rd;
  assign x_rd_en = w_rd;
  assign b_rd_en = r_state == S_BIAS;
  assign w_addr = w_rd ? WAW'(int'(r_m) * N + int'(w_n)) : '0;
  assign x_addr = w_rd ? XAW'(int'(r_b) * N + int'(w_n)) : '0;
  assign b_addr = b_rd_en ? r_m : '0;
  assign busy = r_state == S_BIAS || r_state == S_MAC || r_state == S_OUT;
  assign done = r_state == S_DONE;
  assign y_valid = r_state == S_OUT;
  assign y_data = r_y;
  assign y_batch = r_b;
  assign y_neuron = r_m;
  // next-state: IDLE -> BIAS -> MAC x N -> OUT -> BIAS | DONE -> IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = start ? S_BIAS : S_IDLE;
      S_BIAS: w_next = S_MAC;
      S_MAC:  w_next = w_last_k ? S_OUT : S_MAC;
      S_OUT:  w_next = !y_ready ? S_OUT : w_last_item ? S_DONE : S_BIAS;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // indices, accumulator, result register and ReLU latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b <= '0;
      r_m <= '0;
      r_k <= '0;
      r_acc <= '0;
      r_y <= '0;
      r_relu <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_b <= '0;
        r_m <= '0;
        r_k <= '0;
        r_relu <= relu_en;
      end
      if (r_state == S_MAC) begin
        r_acc <= w_sum;
        r_k <= w_last_k ? '0 : KW'(r_k + 1'b1);
        if (w_last_k) r_y <= w_y;
      end
      if (w_fire) begin
        r_m <= (w_last_m || w_last_item) ? '0 : MW'(r_m + 1'b1);
        r_b <= w_last_item ? '0 : w_last_m ? BW'(r_b + 1'b1) : r_b;
      end
    end
  end
endmodule

// File: tb/tb_dense_seq_ctrl.sv
// tb_dense_seq_ctrl: scoreboard bench for dense_seq_ctrl with B=2, M=3, N=2
module tb_dense_seq_ctrl;
  localparam int B = 2;
  localparam int M = 3;
  localparam int N = 2;
  localparam int W = 16;
  localparam int WAW = $clog2(M * N);
  localparam int XAW = $clog2(B * N);
  localparam int MW = $clog2(M);
  localparam int BW = 1;
  logic clk = 0, rst = 1, start = 0, relu_en = 0, y_ready = 1;
  logic busy, done, w_rd_en, x_rd_en, b_rd_en, y_valid;
  logic [WAW-1:0] w_addr;
  logic [XAW-1:0] x_addr;
  logic [MW-1:0] b_addr, y_neuron;
  logic [BW-1:0] y_batch;
  logic signed [W-1:0] w_data, x_data, b_data, y_data;
  logic signed [W-1:0] wmem [M*N] = '{16'sd256, -16'sd128, 16'sd0, 16'sd0, 16'sd32767, 16'sd32767};
  logic signed [W-1:0] xmem [B*N] = '{16'sd256, 16'sd512, 16'sd32767, 16'sd32767};
  logic signed [W-1:0] bmem [M] = '{16'sd64, -16'sd256, 16'sd0};
  typedef struct {int b; int m; int d;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, cnt_w = 0, cnt_b = 0, n_e = 0, m_e = 0, b_e = 0;
`ifdef DENSE_SEQ_SAT_EN
  int exp0[6] = '{64, -256, 32767, 16447, -256, 32767};
  int exp1[6] = '{64, 0, 32767, 16447, 0, 32767};
`else
  int exp0[6] = '{64, -256, 32765, 16447, -256, -512};
  int exp1[6] = '{64, 0, 32765, 16447, 0, 0};
`endif

  dense_seq_ctrl #(.B(B), .M(M), .N(N), .WIDTH(W), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .x_rd_en(x_rd_en), .x_addr(x_addr), .x_data(x_data),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_data(b_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_batch(y_batch), .y_neuron(y_neuron)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_rd_en) w_data <= wmem[w_addr];
    if (x_rd_en) x_data <= xmem[x_addr];
    if (b_rd_en) b_data <= bmem[b_addr];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint outs();
    return {busy, done, w_rd_en, w_addr, x_rd_en, x_addr, b_rd_en, b_addr, y_valid, y_data, y_batch, y_neuron};
  endfunction

  always @(negedge clk) begin
    if (!rst && y_valid) begin
      chk("rd_during_out", {w_rd_en, x_rd_en, b_rd_en}, 0);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got batch %0d neuron %0d, expected none", y_batch, y_neuron);
      end else begin
        chk("y_data", y_data, q[0].d);
        chk("y_batch", y_batch, q[0].b);
        chk("y_neuron", y_neuron, q[0].m);
        if (y_ready) void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst || !busy) begin
      n_e = 0;
      m_e = 0;
      b_e = 0;
    end else begin
      if (b_rd_en) begin
        cnt_b++;
        chk("b_addr", b_addr, m_e);
      end
      if (w_rd_en) begin
        cnt_w++;
        chk("w_addr", w_addr, m_e * N + n_e);
        chk("x_addr", x_addr, b_e * N + n_e);
        n_e++;
        if (n_e == N) begin
          n_e = 0;
          m_e++;
          if (m_e == M) begin
            m_e = 0;
            b_e++;
          end
        end
      end
    end
  end

  task automatic run(input bit relu, input bit stall, input bit abuse);
    int cyc, fv, dc, st, w0, b0;
    for (int i = 0; i < B * M; i++) q.push_back('{i / M, i % M, relu ? exp1[i] : exp0[i]});
    w0 = cnt_w;
    b0 = cnt_b;
    y_ready = !stall;
    relu_en = relu;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    relu_en = 0;
    cyc = 1;
    fv = 0;
    dc = 0;
    st = 0;
    while (dc == 0 && cyc < 300) begin
      start = abuse && cyc == 2;
      relu_en = (abuse && cyc == 2) ? !relu : 1'b0;
      if (y_valid && fv == 0) fv = cyc;
      if (done) begin
        dc = cyc;
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", y_valid, 0);
      end
      if (stall) begin
        if (!y_valid) begin
          y_ready = 0;
          st = 0;
        end else if (!y_ready) begin
          st++;
          if (st == 6) y_ready = 1;
        end
      end
      @(posedge clk);
      #1 cyc++;
    end
    start = 0;
    relu_en = 0;
    chk("done_seen", dc != 0, 1);
    if (!stall) begin
      chk("first_valid_cycle", fv, N + 2);
      chk("done_cycle", dc, B * M * (N + 2) + 1);
    end
    chk("weight_reads", cnt_w - w0, B * M * N);
    chk("bias_reads", cnt_b - b0, B * M);
    chk("results_left", q.size(), 0);
    q.delete();
    y_ready = 1;
    repeat (3) begin
      @(posedge clk);
      #1 chk("idle_after_done", {done, busy, y_valid}, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk("outs_in_reset", outs(), 0);
    rst = 0;
    @(posedge clk);
    #1 chk("idle_after_reset", {busy, done, y_valid}, 0);
    run(0, 0, 0);
    run(1, 0, 0);
    run(1, 1, 0);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1 chk("outs_on_abort", outs(), 0);
    @(posedge clk);
    #1 rst = 0;
    repeat (4) begin
      @(posedge clk);
      #1 chk("quiet_after_abort", {done, busy, y_valid}, 0);
    end
    run(0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
